// File: rtl/counter_seq_ctrl.sv
// Triangle-sweep sequencer for one up/down counter: clear, count up to up_limit, down to dn_limit, repeat.
// Define CNT_SEQ_DWELL_EN to add the dwell input, which holds the counter at each turning point.
module counter_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] up_limit,
  input  logic [WIDTH-1:0] dn_limit,
  input  logic [CYC_W-1:0] num_cycles,
`ifdef CNT_SEQ_DWELL_EN
  input  logic [7:0]       dwell,
`endif
  input  logic [WIDTH-1:0] count,
  input  logic             ovflw,
  output logic             cnt_rst_n,
  output logic             cnt_act,
  output logic             cnt_up_dwn_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cycles_done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    UP,
    DOWN
`ifdef CNT_SEQ_DWELL_EN
    , DWELL
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] l_up;
  logic [WIDTH-1:0] l_dn;
  logic [CYC_W-1:0] l_n;
  logic [CYC_W-1:0] cycles_next;
  logic             at_peak;
  logic             at_floor;
  logic             last_pair;
  logic             abort;

`ifdef CNT_SEQ_DWELL_EN
  logic [7:0]       l_dwell;
  logic [7:0]       dwell_cnt;
  logic             dwell_up;
  logic             dwell_on;
  assign dwell_on = (l_dwell != 8'd0);
`endif

  assign cycles_next = cycles_done + CYC_W'(1);
  assign at_peak     = (state == UP) && (count == l_up);
  assign at_floor    = (state == DOWN) && (count == l_dn);
  assign last_pair   = (cycles_next == l_n);
  assign abort       = (state != IDLE) && (stop || ovflw);

  // Counter controls are decoded from the present count so the turn lands exactly on a limit.
  always_comb begin
    cnt_rst_n    = !rst && (state != CLEAR);
    cnt_act      = 1'b0;
    cnt_up_dwn_n = 1'b1;
    case (state)
      UP: begin
        cnt_act = 1'b1;
        if (at_peak) begin
          cnt_up_dwn_n = 1'b0;
`ifdef CNT_SEQ_DWELL_EN
          if (dwell_on) cnt_act = 1'b0;
`endif
        end
      end
      DOWN: begin
        cnt_act      = 1'b1;
        cnt_up_dwn_n = 1'b0;
        if (at_floor) begin
          if (last_pair) begin
            cnt_act = 1'b0;
          end else begin
            cnt_up_dwn_n = 1'b1;
`ifdef CNT_SEQ_DWELL_EN
            if (dwell_on) cnt_act = 1'b0;
`endif
          end
        end
      end
`ifdef CNT_SEQ_DWELL_EN
      // The last dwell cycle already steps the counter in the new direction.
      DWELL: begin
        cnt_act      = (dwell_cnt == 8'd0);
        cnt_up_dwn_n = dwell_up;
      end
`endif
      default: ;
    endcase
    if (rst || abort) cnt_act = 1'b0;
    if (rst) cnt_up_dwn_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycles_done <= '0;
      l_up        <= '0;
      l_dn        <= '0;
      l_n         <= '0;
`ifdef CNT_SEQ_DWELL_EN
      l_dwell     <= '0;
      dwell_cnt   <= '0;
      dwell_up    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (!stop) err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if ((up_limit <= dn_limit) || (num_cycles == '0)) begin
                err <= 1'b1;
              end else begin
                l_up        <= up_limit;
                l_dn        <= dn_limit;
                l_n         <= num_cycles;
`ifdef CNT_SEQ_DWELL_EN
                l_dwell     <= dwell;
`endif
                err         <= 1'b0;
                cycles_done <= '0;
                busy        <= 1'b1;
                state       <= CLEAR;
              end
            end
          end
          CLEAR: state <= UP;
          UP: begin
            if (at_peak) begin
`ifdef CNT_SEQ_DWELL_EN
              if (dwell_on) begin
                dwell_cnt <= l_dwell - 8'd1;
                dwell_up  <= 1'b0;
                state     <= DWELL;
              end else begin
                state <= DOWN;
              end
`else
              state <= DOWN;
`endif
            end
          end
          DOWN: begin
            if (at_floor) begin
              cycles_done <= cycles_next;
              if (last_pair) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
`ifdef CNT_SEQ_DWELL_EN
                if (dwell_on) begin
                  dwell_cnt <= l_dwell - 8'd1;
                  dwell_up  <= 1'b1;
                  state     <= DWELL;
                end else begin
                  state <= UP;
                end
`else
                state <= UP;
`endif
              end
            end
          end
`ifdef CNT_SEQ_DWELL_EN
          DWELL: begin
            if (dwell_cnt == 8'd0) state <= dwell_up ? UP : DOWN;
            else dwell_cnt <= dwell_cnt - 8'd1;
          end
`endif
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomised bench for counter_seq_ctrl with a behavioural counter and a count-sequence reference model.
// Dwell sweeps are exercised when CNT_SEQ_DWELL_EN is defined.
module tb_counter_seq_ctrl;
  localparam int WIDTH = 5;
  localparam int CYC_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] up_limit;
  logic [WIDTH-1:0] dn_limit;
  logic [CYC_W-1:0] num_cycles;
`ifdef CNT_SEQ_DWELL_EN
  logic [7:0]       dwell;
`endif
  logic [WIDTH-1:0] count = '0;
  logic             ovflw;
  logic             cnt_rst_n;
  logic             cnt_act;
  logic             cnt_up_dwn_n;
  logic             busy;
  logic             done;
  logic             err;
  logic [CYC_W-1:0] cycles_done;

  int vectors = 0;
  int miscompares = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .up_limit(up_limit), .dn_limit(dn_limit), .num_cycles(num_cycles),
`ifdef CNT_SEQ_DWELL_EN
    .dwell(dwell),
`endif
    .count(count), .ovflw(ovflw),
    .cnt_rst_n(cnt_rst_n), .cnt_act(cnt_act), .cnt_up_dwn_n(cnt_up_dwn_n),
    .busy(busy), .done(done), .err(err), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // Behavioural model of the counter being sequenced.
  always @(posedge clk) begin
    if (!cnt_rst_n) count <= '0;
    else if (cnt_act) count <= cnt_up_dwn_n ? count + 5'd1 : count - 5'd1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int u, input int d, input int n, input int dw);
    @(negedge clk);
    up_limit   = WIDTH'(u);
    dn_limit   = WIDTH'(d);
    num_cycles = CYC_W'(n);
`ifdef CNT_SEQ_DWELL_EN
    dwell      = 8'(dw);
`endif
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Expected count per cycle, built from the sweep rules: 0 -> u -> d, n times, dwell repeats at each turn.
  task automatic runSweep(input int u, input int d, input int n, input int dw);
    int q[$];
    int cur;
    int last;
    q.push_back(0);
    cur = 0;
    for (int leg = 0; leg < n; leg++) begin
      while (cur < u) begin cur++; q.push_back(cur); end
      for (int k = 0; k < dw; k++) q.push_back(u);
      while (cur > d) begin cur--; q.push_back(cur); end
      if (leg < n - 1) for (int k = 0; k < dw; k++) q.push_back(d);
    end
    last = q.size() - 1;

    applyStimulus(u, d, n, dw);
    checkOutput("clear_rst_n", 32'(cnt_rst_n), 0);
    checkOutput("clear_act", 32'(cnt_act), 0);
    checkOutput("clear_busy", 32'(busy), 1);
    checkOutput("clear_err", 32'(err), 0);

    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput("sweep_count", 32'(count), 32'(q[i]));
      checkOutput("sweep_busy", 32'(busy), 1);
      checkOutput("sweep_done", 32'(done), 0);
      if (i < last) begin
        checkOutput("sweep_act", 32'(cnt_act), 32'(q[i+1] != q[i]));
        if (q[i+1] != q[i]) checkOutput("sweep_dir", 32'(cnt_up_dwn_n), 32'(q[i+1] > q[i]));
      end else begin
        checkOutput("final_act", 32'(cnt_act), 0);
      end
      // A start pulse with different limits mid-sweep must not disturb the latched configuration.
      if (i == last / 2) begin
        start    = 1'b1;
        up_limit = WIDTH'($urandom_range(1, 31));
        dn_limit = '0;
      end
    end
    @(negedge clk);
    checkOutput("end_done", 32'(done), 1);
    checkOutput("end_busy", 32'(busy), 0);
    checkOutput("end_count", 32'(count), 32'(d));
    checkOutput("end_cycles", 32'(cycles_done), 32'(n));
    @(negedge clk);
    checkOutput("post_done", 32'(done), 0);
    checkOutput("post_count", 32'(count), 32'(d));
  endtask

  task automatic waitCount(input int target, output bit found);
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (count == WIDTH'(target) && busy) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    int u, d, n, dw;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ovflw = 1'b0;
    up_limit = '0; dn_limit = '0; num_cycles = '0;
`ifdef CNT_SEQ_DWELL_EN
    dwell = '0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_cnt_rst_n", 32'(cnt_rst_n), 0);
    checkOutput("rst_act", 32'(cnt_act), 0);
    checkOutput("rst_dir", 32'(cnt_up_dwn_n), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_cycles", 32'(cycles_done), 0);
    rst = 1'b0;

    $display("[TB] bad configurations");
    applyStimulus(3, 3, 2, 0);
    checkOutput("bad_eq_err", 32'(err), 1);
    checkOutput("bad_eq_busy", 32'(busy), 0);
    checkOutput("bad_eq_act", 32'(cnt_act), 0);
    checkOutput("bad_eq_rst_n", 32'(cnt_rst_n), 1);
    applyStimulus(5, 2, 0, 0);
    checkOutput("bad_n0_err", 32'(err), 1);
    checkOutput("bad_n0_busy", 32'(busy), 0);
    applyStimulus(2, 6, 1, 0);
    @(negedge clk);
    checkOutput("bad_lt_err", 32'(err), 1);
    checkOutput("bad_lt_act", 32'(cnt_act), 0);

    $display("[TB] directed sweeps");
    runSweep(4, 1, 2, 0);
    runSweep(31, 0, 1, 0);
`ifdef CNT_SEQ_DWELL_EN
    runSweep(2, 0, 1, 3);
`endif

    $display("[TB] abort by stop");
    applyStimulus(20, 0, 5, 0);
    waitCount(7, found);
    if (!found) checkOutput("abort_reach", 32'(count), 7);
    stop = 1'b1;
    #1;
    checkOutput("abort_act", 32'(cnt_act), 0);
    @(negedge clk);
    stop = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_cycles", 32'(cycles_done), 0);
    checkOutput("abort_err", 32'(err), 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_count", 32'(count), 7);
      checkOutput("abort_done", 32'(done), 0);
    end

    $display("[TB] forced overflow");
    applyStimulus(20, 0, 5, 0);
    waitCount(5, found);
    if (!found) checkOutput("fault_reach", 32'(count), 5);
    ovflw = 1'b1;
    #1;
    checkOutput("fault_act", 32'(cnt_act), 0);
    @(negedge clk);
    ovflw = 1'b0;
    checkOutput("fault_err", 32'(err), 1);
    checkOutput("fault_busy", 32'(busy), 0);
    checkOutput("fault_done", 32'(done), 0);
    @(negedge clk);
    checkOutput("fault_hold", 32'(count), 5);
    checkOutput("fault_err_sticky", 32'(err), 1);

    $display("[TB] reset mid-sweep");
    applyStimulus(3, 1, 3, 0);
    repeat (9) @(negedge clk);
    checkOutput("midrst_cycles_pre", 32'(cycles_done), 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rst_n", 32'(cnt_rst_n), 0);
    checkOutput("midrst_act", 32'(cnt_act), 0);
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_done", 32'(done), 0);
    checkOutput("midrst_err", 32'(err), 0);
    checkOutput("midrst_cycles", 32'(cycles_done), 0);
    checkOutput("midrst_count", 32'(count), 0);
    rst = 1'b0;

    $display("[TB] random sweeps");
    for (int r = 0; r < 8; r++) begin
      d  = $urandom_range(0, 10);
      u  = $urandom_range(d + 1, 14);
      n  = $urandom_range(1, 3);
`ifdef CNT_SEQ_DWELL_EN
      dw = $urandom_range(0, 3);
`else
      dw = 0;
`endif
      runSweep(u, d, n, dw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
